// File: rtl/tdm_demux_4ch_pkg.sv
// Shared types and constants for the four-channel TDM demultiplexer.
package tdm_demux_4ch_pkg;

   // Framing FSM: HUNT waits for a frame marker, LOCK follows slots 0..3.
   typedef enum logic {
      HUNT = 1'b0,
      LOCK = 1'b1
   } state_e;

   localparam int NUM_CH = 4;

   localparam logic [1:0] SLOT_A = 2'd0;
   localparam logic [1:0] SLOT_B = 2'd1;
   localparam logic [1:0] SLOT_C = 2'd2;
   localparam logic [1:0] SLOT_D = 2'd3;

   // One-hot strobe pattern for a slot index (bit0 = channel A).
   function automatic logic [3:0] slotStrobe(input logic [1:0] s);
      return 4'b0001 << s;
   endfunction

endpackage

// File: rtl/tdm_demux_4ch_sat_counter.sv
// Saturating up-counter used for the framing error count.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc_i,
   output logic [W-1:0] count_o
);

   logic [W-1:0] count_q;

   // Count up on each increment request, sticking at the all-ones value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else if (inc_i && (count_q != '1)) begin
         count_q <= count_q + W'(1);
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/tdm_demux_4ch.sv
// Four-channel TDM demultiplexer: locks onto a sync-marked frame and fans
// each time slot out to its own registered channel output.
module tdm_demux_4ch
   import tdm_demux_4ch_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int ERR_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic             in_sync,
   input  logic [WIDTH-1:0] in_data,
   output logic [WIDTH-1:0] out_a,
   output logic [WIDTH-1:0] out_b,
   output logic [WIDTH-1:0] out_c,
   output logic [WIDTH-1:0] out_d,
   output logic [3:0]       out_strobe,
   output logic             frame_done,
   output logic             locked,
   output logic [1:0]       slot,
   output logic [ERR_W-1:0] err_cnt
);

   state_e           state_q, state_d;
   logic [1:0]       slot_q, slot_d;
   logic [WIDTH-1:0] chan_q [NUM_CH];
   logic [WIDTH-1:0] chan_d [NUM_CH];
   logic [3:0]       strobe_q, strobe_d;
   logic             frameDone_q, frameDone_d;
   logic             errInc;

   // Register all framing state and channel outputs; reset drops any partial frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= HUNT;
         slot_q      <= SLOT_A;
         strobe_q    <= '0;
         frameDone_q <= 1'b0;
         for (int i = 0; i < NUM_CH; i++) begin
            chan_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         slot_q      <= slot_d;
         strobe_q    <= strobe_d;
         frameDone_q <= frameDone_d;
         for (int i = 0; i < NUM_CH; i++) begin
            chan_q[i] <= chan_d[i];
         end
      end
   end

   // Next-state decode: a valid sync sample always restarts at slot A; an
   // unsynced sample is written only while locked and off slot A.
   always_comb begin
      state_d     = state_q;
      slot_d      = slot_q;
      chan_d      = chan_q;
      strobe_d    = '0;
      frameDone_d = 1'b0;
      errInc      = 1'b0;
      if (in_valid) begin
         if (in_sync) begin
            chan_d[SLOT_A] = in_data;
            strobe_d       = slotStrobe(SLOT_A);
            slot_d         = SLOT_B;
            state_d        = LOCK;
            if ((state_q == LOCK) && (slot_q != SLOT_A)) begin
               errInc = 1'b1;
            end
         end else if (state_q == LOCK) begin
            if (slot_q == SLOT_A) begin
               errInc  = 1'b1;
               state_d = HUNT;
               slot_d  = SLOT_A;
            end else begin
               chan_d[slot_q] = in_data;
               strobe_d       = slotStrobe(slot_q);
               slot_d         = slot_q + 2'd1;
               frameDone_d    = (slot_q == SLOT_D);
            end
         end
      end
   end

   sat_counter #(
      .W(ERR_W)
   ) uErrCnt (
      .clk    (clk),
      .rst_n  (rst_n),
      .inc_i  (errInc),
      .count_o(err_cnt)
   );

   assign out_a      = chan_q[SLOT_A];
   assign out_b      = chan_q[SLOT_B];
   assign out_c      = chan_q[SLOT_C];
   assign out_d      = chan_q[SLOT_D];
   assign out_strobe = strobe_q;
   assign frame_done = frameDone_q;
   assign locked     = (state_q == LOCK);
   assign slot       = slot_q;

endmodule

// File: tb/tb_tdm_demux_4ch.sv
// Scoreboard bench for the TDM demultiplexer, built with a 2-bit error counter
// so saturation is reachable with a handful of framing errors.
module tb_tdm_demux_4ch;

   localparam int WIDTH = 8;
   localparam int ERR_W = 2;

   typedef struct {
      logic [3:0]       strobe;
      logic [WIDTH-1:0] a, b, c, d;
      logic             fd;
      logic [ERR_W-1:0] err;
      logic             lck;
      logic [1:0]       slt;
   } packet_t;

   logic             clk;
   logic             rst_n;
   logic             inValid;
   logic             inSync;
   logic [WIDTH-1:0] inData;
   logic [WIDTH-1:0] outA, outB, outC, outD;
   logic [3:0]       outStrobe;
   logic             frameDone;
   logic             locked;
   logic [1:0]       slot;
   logic [ERR_W-1:0] errCnt;

   int checks   = 0;
   int failures = 0;

   packet_t          sb[$];
   logic [WIDTH-1:0] chanExp [4];

   tdm_demux_4ch #(
      .WIDTH(WIDTH),
      .ERR_W(ERR_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (inValid),
      .in_sync   (inSync),
      .in_data   (inData),
      .out_a     (outA),
      .out_b     (outB),
      .out_c     (outC),
      .out_d     (outD),
      .out_strobe(outStrobe),
      .frame_done(frameDone),
      .locked    (locked),
      .slot      (slot),
      .err_cnt   (errCnt)
   );

   // Free-running 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Watchdog so the run always ends even if something stalls.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Monitor: every strobe the DUT presents must match the next queued expectation.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (outStrobe != 4'b0000) begin
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("[TB] FAIL unexpected_strobe: actual=%b required=none", outStrobe);
            end else begin
               packet_t p;
               p = sb.pop_front();
               checkOutput("pkt_strobe", 32'(outStrobe), 32'(p.strobe));
               checkOutput("pkt_out_a", 32'(outA), 32'(p.a));
               checkOutput("pkt_out_b", 32'(outB), 32'(p.b));
               checkOutput("pkt_out_c", 32'(outC), 32'(p.c));
               checkOutput("pkt_out_d", 32'(outD), 32'(p.d));
               checkOutput("pkt_frame_done", 32'(frameDone), 32'(p.fd));
               checkOutput("pkt_err_cnt", 32'(errCnt), 32'(p.err));
               checkOutput("pkt_locked", 32'(locked), 32'(p.lck));
               checkOutput("pkt_slot", 32'(slot), 32'(p.slt));
            end
         end else if (frameDone !== 1'b0) begin
            checks++;
            failures++;
            $display("[TB] FAIL frame_done_without_strobe: actual=%b required=0", frameDone);
         end
      end
   end

   // Drive one valid sample for one clock; queue the hand-computed response if a strobe is due.
   task automatic applyStimulus(input logic [WIDTH-1:0] data, input logic sync,
                                input logic [3:0] expStrobe, input logic expFd,
                                input int expErr, input logic [1:0] expSlot);
      packet_t p;
      inValid = 1'b1;
      inSync  = sync;
      inData  = data;
      if (expStrobe != 4'b0000) begin
         for (int n = 0; n < 4; n++) begin
            if (expStrobe[n]) chanExp[n] = data;
         end
         p.strobe = expStrobe;
         p.a      = chanExp[0];
         p.b      = chanExp[1];
         p.c      = chanExp[2];
         p.d      = chanExp[3];
         p.fd     = expFd;
         p.err    = ERR_W'(expErr);
         p.lck    = 1'b1;
         p.slt    = expSlot;
         sb.push_back(p);
      end
      @(posedge clk);
      #1;
      inValid = 1'b0;
      inSync  = 1'b1;
      inData  = 8'hEE;
   endtask

   task automatic idle(input int n);
      inValid = 1'b0;
      inSync  = 1'b1;
      repeat (n) @(posedge clk);
      #1;
      inSync  = 1'b0;
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_out_a"}, 32'(outA), 32'h0);
      checkOutput({tag, "_out_b"}, 32'(outB), 32'h0);
      checkOutput({tag, "_out_c"}, 32'(outC), 32'h0);
      checkOutput({tag, "_out_d"}, 32'(outD), 32'h0);
      checkOutput({tag, "_strobe"}, 32'(outStrobe), 32'h0);
      checkOutput({tag, "_frame_done"}, 32'(frameDone), 32'h0);
      checkOutput({tag, "_locked"}, 32'(locked), 32'h0);
      checkOutput({tag, "_err_cnt"}, 32'(errCnt), 32'h0);
      checkOutput({tag, "_slot"}, 32'(slot), 32'h0);
   endtask

   // Assert reset away from any edge, confirm it clears outputs without a clock, then release.
   task automatic applyReset(input string tag);
      rst_n = 1'b0;
      #1;
      checkAllZero(tag);
      sb.delete();
      for (int n = 0; n < 4; n++) chanExp[n] = '0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic checkDrained(input string tag);
      idle(2);
      checkOutput({tag, "_queue_drained"}, 32'(sb.size()), 32'h0);
   endtask

   initial begin
      rst_n   = 1'b0;
      inValid = 1'b0;
      inSync  = 1'b0;
      inData  = '0;
      #12;

      // Basic back-to-back frame.
      applyReset("rst0");
      applyStimulus(8'h11, 1'b1, 4'b0001, 1'b0, 0, 2'd1);
      applyStimulus(8'h22, 1'b0, 4'b0010, 1'b0, 0, 2'd2);
      applyStimulus(8'h33, 1'b0, 4'b0100, 1'b0, 0, 2'd3);
      applyStimulus(8'h44, 1'b0, 4'b1000, 1'b1, 0, 2'd0);
      checkDrained("frame");
      checkOutput("frame_locked", 32'(locked), 32'h1);
      checkOutput("frame_err_cnt", 32'(errCnt), 32'h0);

      // Unsynced samples in HUNT are dropped.
      applyReset("rst1");
      applyStimulus(8'h55, 1'b0, 4'b0000, 1'b0, 0, 2'd0);
      applyStimulus(8'h66, 1'b0, 4'b0000, 1'b0, 0, 2'd0);
      checkOutput("hunt_locked", 32'(locked), 32'h0);
      applyStimulus(8'hA1, 1'b1, 4'b0001, 1'b0, 0, 2'd1);
      checkDrained("hunt");
      checkOutput("hunt_out_a", 32'(outA), 32'hA1);
      checkOutput("hunt_out_b", 32'(outB), 32'h00);
      checkOutput("hunt_err_cnt", 32'(errCnt), 32'h0);

      // Early sync restarts the frame and counts an error.
      applyReset("rst2");
      applyStimulus(8'h01, 1'b1, 4'b0001, 1'b0, 0, 2'd1);
      applyStimulus(8'h02, 1'b0, 4'b0010, 1'b0, 0, 2'd2);
      applyStimulus(8'h09, 1'b1, 4'b0001, 1'b0, 1, 2'd1);
      checkDrained("early");
      checkOutput("early_out_b_held", 32'(outB), 32'h02);

      // Missing sync after a full frame drops lock; next sync relocks.
      applyReset("rst3");
      applyStimulus(8'h11, 1'b1, 4'b0001, 1'b0, 0, 2'd1);
      applyStimulus(8'h22, 1'b0, 4'b0010, 1'b0, 0, 2'd2);
      applyStimulus(8'h33, 1'b0, 4'b0100, 1'b0, 0, 2'd3);
      applyStimulus(8'h44, 1'b0, 4'b1000, 1'b1, 0, 2'd0);
      applyStimulus(8'h77, 1'b0, 4'b0000, 1'b0, 0, 2'd0);
      checkDrained("miss");
      checkOutput("miss_locked", 32'(locked), 32'h0);
      checkOutput("miss_err_cnt", 32'(errCnt), 32'h1);
      checkOutput("miss_slot", 32'(slot), 32'h0);
      checkOutput("miss_out_a_held", 32'(outA), 32'h11);
      applyStimulus(8'h88, 1'b1, 4'b0001, 1'b0, 1, 2'd1);
      checkDrained("relock");

      // Same frame with idle gaps between samples.
      applyReset("rst4");
      idle(1);
      applyStimulus(8'h11, 1'b1, 4'b0001, 1'b0, 0, 2'd1);
      idle(2);
      applyStimulus(8'h22, 1'b0, 4'b0010, 1'b0, 0, 2'd2);
      idle(1);
      applyStimulus(8'h33, 1'b0, 4'b0100, 1'b0, 0, 2'd3);
      idle(3);
      applyStimulus(8'h44, 1'b0, 4'b1000, 1'b1, 0, 2'd0);
      checkDrained("gaps");
      checkOutput("gaps_locked", 32'(locked), 32'h1);

      // Five early syncs saturate the 2-bit counter, then reset lands mid-frame.
      applyReset("rst5");
      applyStimulus(8'h01, 1'b1, 4'b0001, 1'b0, 0, 2'd1);
      applyStimulus(8'h02, 1'b1, 4'b0001, 1'b0, 1, 2'd1);
      applyStimulus(8'h03, 1'b1, 4'b0001, 1'b0, 2, 2'd1);
      applyStimulus(8'h04, 1'b1, 4'b0001, 1'b0, 3, 2'd1);
      applyStimulus(8'h05, 1'b1, 4'b0001, 1'b0, 3, 2'd1);
      applyStimulus(8'h06, 1'b1, 4'b0001, 1'b0, 3, 2'd1);
      applyStimulus(8'h07, 1'b0, 4'b0010, 1'b0, 3, 2'd2);
      @(negedge clk);
      #2;
      checkOutput("sat_err_cnt", 32'(errCnt), 32'h3);
      checkOutput("sat_queue_drained", 32'(sb.size()), 32'h0);
      applyReset("midrst");
      applyStimulus(8'h12, 1'b0, 4'b0000, 1'b0, 0, 2'd0);
      checkOutput("postrst_out_b", 32'(outB), 32'h00);
      applyStimulus(8'h34, 1'b1, 4'b0001, 1'b0, 0, 2'd1);
      checkDrained("postrst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/tdm_demux_4ch.md
TDM_DEMUX_4CH -- requirements
Module: tdm_demux_4ch

Interface
REQ-001 Parameter: WIDTH, default 8, data width of every sample and output channel.
REQ-002 Parameter: ERR_W, default 8, width of the error counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  sample present on in_data this cycle.
REQ-006 in_sync  input  1  frame marker; qualified by in_valid; marks the slot-0 sample.
REQ-007 in_data  input  WIDTH  time-multiplexed sample.
REQ-008 out_a, out_b, out_c, out_d  output  WIDTH each  registered channel values for slots 0/1/2/3; hold until rewritten.
REQ-009 out_strobe  output  4  one-cycle pulse; bit n set in the cycle channel n updates (bit0=A … bit3=D).
REQ-010 frame_done  output  1  one-cycle pulse coincident with the slot-3 (D) update.
REQ-011 locked  output  1  high while the FSM is in LOCK.
REQ-012 slot  output  2  next expected slot index.
REQ-013 err_cnt  output  ERR_W  saturating count of framing errors.

Function
REQ-014 The FSM SHALL have two states: HUNT and LOCK.
REQ-015 All outputs SHALL be registered; latency from accepted sample to out_x/out_strobe SHALL be exactly 1 cycle.
REQ-016 Cycles with in_valid=0 SHALL change no state and produce no pulses; in_sync without in_valid SHALL be ignored.
REQ-017 HUNT, in_valid=1, in_sync=0: sample discarded, no strobe, stay HUNT, err_cnt unchanged.
REQ-018 HUNT, in_valid=1, in_sync=1: write out_a, pulse out_strobe[0], slot<=1, go LOCK.
REQ-019 LOCK, in_valid=1, in_sync=0, slot=1..3: write the channel indexed by slot, pulse its strobe bit, slot<=slot+1 modulo 4.
REQ-020 Slot 3 write SHALL also pulse frame_done; slot SHALL wrap to 0.
REQ-021 LOCK, slot=0, in_valid=1, in_sync=1: normal frame start, behave as REQ-018, stay LOCK.
REQ-022 LOCK, slot=0, in_valid=1, in_sync=0 (missing sync): discard sample, err_cnt+1, go HUNT, slot<=0.
REQ-023 LOCK, slot≠0, in_valid=1, in_sync=1 (early sync): err_cnt+1, treat sample as slot 0 (write out_a, strobe[0]), slot<=1, stay LOCK; no frame_done.
REQ-024 err_cnt SHALL saturate at 2^ERR_W-1 and never wrap.
REQ-025 At most one out_strobe bit SHALL be set in any cycle.
REQ-026 Channel values not being written SHALL hold their previous contents.

Reset
REQ-027 rst_n low SHALL immediately force: state HUNT, slot 0, out_a..out_d 0, out_strobe 0, frame_done 0, locked 0, err_cnt 0.
REQ-028 Reset asserted mid-frame SHALL discard the partial frame; after release the block SHALL require a new in_sync before any write.
REQ-029 First sample SHALL be accepted on the first rising edge after rst_n deasserts.

Structure
REQ-030 A shared package SHALL hold the FSM state enumeration (HUNT, LOCK) and slot-index constants SLOT_A..SLOT_D (0..3).
REQ-031 One sub-module, sat_counter (saturating up-counter, width parameter, inc input), SHALL implement err_cnt; everything else SHALL be in tdm_demux_4ch.

Verification
REQ-032 Reset then frame 0x11(sync),0x22,0x33,0x44 back-to-back -> out_a..d=11/22/33/44, strobes 0001,0010,0100,1000 on consecutive cycles, frame_done with D, err_cnt=0, locked=1.
REQ-033 In HUNT, send 0x55,0x66 without sync then 0xA1(sync) -> first two ignored, out_a=A1, err_cnt=0.
REQ-034 Locked, after 0x01(sync),0x02, send 0x09 with sync -> err_cnt=1, out_a=09, out_b=02 held, slot=1, no frame_done.
REQ-035 Complete frame then 0x77 without sync -> no strobe, err_cnt increments by 1, locked=0; next sync sample relocks.
REQ-036 Frame with in_valid gaps (idle cycles between samples) -> identical outputs to REQ-032, strobes only on valid cycles.
REQ-037 ERR_W=2, force five framing errors -> err_cnt=3 held; assert rst_n low mid-frame -> all outputs 0 asynchronously, locked=0.
